game_ctrl: RTL and testbench



---
 rtl/game_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game flow controller for the flappy-bird datapath: IDLE -> PLAY -> OVER,
// with collision debouncing over frame ticks, a restart hold-off and a best-score register.
module game_ctrl #(
  parameter int BIRD_X_L   = 300,
  parameter int BIRD_X_R   = 320,
  parameter int BIRD_H     = 20,
  parameter int FLOOR_Y    = 460,
  parameter int HIT_FRAMES = 2,
  parameter int OVER_HOLD  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Btn,
  input  logic       Tick,
  input  logic [9:0] Bird_Y,
  input  logic [9:0] X_Edge_L,
  input  logic [9:0] X_Edge_R,
  input  logic [9:0] Gap_Top,
  input  logic [9:0] Gap_Bot,
  input  logic [3:0] Score,
  output logic       Start,
  output logic       Stop,
  output logic       Ack,
  output logic       Q_Idle,
  output logic       Q_Play,
  output logic       Q_Over,
  output logic [3:0] Best
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    PLAY = 3'b010,
    OVER = 3'b100
  } state_t;

  localparam logic [10:0] X_L_W    = 11'(BIRD_X_L);
  localparam logic [10:0] X_R_W    = 11'(BIRD_X_R);
  localparam logic [10:0] H_W      = 11'(BIRD_H);
  localparam logic [10:0] FLOOR_W  = 11'(FLOOR_Y);
  localparam logic [3:0]  HIT_MAX  = 4'(HIT_FRAMES);
  localparam logic [7:0]  HOLD_MAX = 8'(OVER_HOLD);

  state_t     state_q, state_d;
  logic       btn_q, btn_d;
  logic       start_q, start_d;
  logic       ack_q, ack_d;
  logic       stop_q, stop_d;
  logic [3:0] best_q, best_d;
  logic [2:0] hit_q, hit_d;
  logic [7:0] hold_q, hold_d;

  logic        rise;
  logic [10:0] bird_bot;
  logic        pipe_hit;
  logic        floor_hit;
  logic        col;
  logic [3:0]  hit_inc;

  // Bottom row is formed at 11 bits so a bird near row 1023 still reads as below the floor.
  assign bird_bot  = {1'b0, Bird_Y} + H_W;
  assign pipe_hit  = ({1'b0, X_Edge_L} <= X_R_W) && ({1'b0, X_Edge_R} >= X_L_W) &&
                     ((Bird_Y < Gap_Top) || (bird_bot > {1'b0, Gap_Bot}));
  assign floor_hit = (bird_bot >= FLOOR_W);
  assign col       = pipe_hit || floor_hit;
  assign rise      = Btn & ~btn_q;
  assign hit_inc   = {1'b0, hit_q} + 4'd1;

  always_comb begin
    state_d = state_q;
    btn_d   = Btn;
    start_d = 1'b0;
    ack_d   = 1'b0;
    stop_d  = stop_q;
    best_d  = best_q;
    hit_d   = hit_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          start_d = 1'b1;
          hit_d   = 3'd0;
          stop_d  = 1'b0;
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (Tick) begin
          if (col) begin
            if (hit_inc >= HIT_MAX) begin
              hit_d   = HIT_MAX[2:0];
              hold_d  = 8'd0;
              stop_d  = 1'b1;
              state_d = OVER;
              if (Score > best_q) begin
                best_d = Score;
              end
            end else begin
              hit_d = hit_inc[2:0];
            end
          end else begin
            hit_d = 3'd0;
          end
        end
      end

      OVER: begin
        // The restart test sees hold_q before this cycle's Tick is counted.
        if (rise && (hold_q == HOLD_MAX)) begin
          ack_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = IDLE;
        end else if (Tick && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      btn_q   <= 1'b1;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      stop_q  <= 1'b0;
      best_q  <= 4'd0;
      hit_q   <= 3'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      stop_q  <= stop_d;
      best_q  <= best_d;
      hit_q   <= hit_d;
      hold_q  <= hold_d;
    end
  end

  assign Start  = start_q;
  assign Stop   = stop_q;
  assign Ack    = ack_q;
  assign Q_Idle = state_q[0];
  assign Q_Play = state_q[1];
  assign Q_Over = state_q[2];
  assign Best   = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized traffic,
// all compared against a rule-level reference model of the game flow.
module tb_game_ctrl;

  localparam int HF = 2;
  localparam int OH = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       Btn;
  logic       Tick;
  logic [9:0] Bird_Y, X_Edge_L, X_Edge_R, Gap_Top, Gap_Bot;
  logic [3:0] Score;
  logic       Start, Stop, Ack, Q_Idle, Q_Play, Q_Over;
  logic [3:0] Best;

  int tests = 0;
  int fails = 0;

  // Reference model: 0 = idle, 1 = play, 2 = over
  int m_state;
  int m_hit;
  int m_hold;
  int m_best;
  bit m_start;
  bit m_ack;
  bit m_btn_prev;

  game_ctrl dut (
    .clk(clk), .reset(reset), .Btn(Btn), .Tick(Tick),
    .Bird_Y(Bird_Y), .X_Edge_L(X_Edge_L), .X_Edge_R(X_Edge_R),
    .Gap_Top(Gap_Top), .Gap_Bot(Gap_Bot), .Score(Score),
    .Start(Start), .Stop(Stop), .Ack(Ack),
    .Q_Idle(Q_Idle), .Q_Play(Q_Play), .Q_Over(Q_Over), .Best(Best)
  );

  always #5 clk = ~clk;

  function automatic bit collide();
    int top, bot, xl, xr, gt, gb;
    top = int'(Bird_Y);
    bot = top + 20;
    xl  = int'(X_Edge_L);
    xr  = int'(X_Edge_R);
    gt  = int'(Gap_Top);
    gb  = int'(Gap_Bot);
    return ((xl <= 320) && (xr >= 300) && ((top < gt) || (bot > gb))) || (bot >= 460);
  endfunction

  function automatic void model_step();
    bit rise;
    if (reset) begin
      m_state = 0; m_start = 0; m_ack = 0; m_best = 0;
      m_hit = 0; m_hold = 0; m_btn_prev = 1;
      return;
    end
    rise = Btn && !m_btn_prev;
    m_btn_prev = Btn;
    m_start = 0;
    m_ack = 0;
    if (m_state == 0) begin
      if (rise) begin
        m_start = 1; m_hit = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (Tick) begin
        if (collide()) begin
          m_hit = (m_hit + 1 > HF) ? HF : m_hit + 1;
          if (m_hit == HF) begin
            m_state = 2;
            m_hold = 0;
            if (int'(Score) > m_best) m_best = int'(Score);
          end
        end else begin
          m_hit = 0;
        end
      end
    end else begin
      if (rise && m_hold == OH) begin
        m_ack = 1; m_state = 0;
      end else if (Tick) begin
        m_hold = (m_hold + 1 > OH) ? OH : m_hold + 1;
      end
    end
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_start, m_state == 2, m_ack, m_state == 0, m_state == 1, m_state == 2, 4'(m_best)};
  endfunction

  function automatic logic [9:0] act_vec();
    return {Start, Stop, Ack, Q_Idle, Q_Play, Q_Over, Best};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_scene(input int y, input int xl, input int xr, input int gt, input int gb);
    Bird_Y = 10'(y); X_Edge_L = 10'(xl); X_Edge_R = 10'(xr); Gap_Top = 10'(gt); Gap_Bot = 10'(gb);
  endtask

  task automatic do_game(input int s);
    Btn = 0; Tick = 0; cyc();
    Btn = 1; cyc();
    Btn = 0;
    Score = 4'(s);
    set_scene(439, 600, 700, 0, 1000);
    repeat (2) begin Tick = 1; cyc(); Tick = 0; cyc(); end
    set_scene(440, 600, 700, 0, 1000);
    repeat (2) begin Tick = 1; cyc(); Tick = 0; cyc(); end
  endtask

  task automatic do_restart();
    repeat (OH) begin Tick = 1; cyc(); Tick = 0; cyc(); end
    Btn = 1; cyc();
    Btn = 0; cyc();
  endtask

  task automatic test_reset();
    reset = 1; Btn = 0; Tick = 0; Score = 0;
    set_scene(100, 600, 700, 0, 1000);
    cyc(); cyc();
    tests++;
    if (act_vec() !== 10'b0001000000) begin
      $display("[TB] FAIL reset_state: got %b want %b", act_vec(), 10'b0001000000); fails++;
    end
    tests++;
    if (act_vec() !== exp_vec()) begin
      $display("[TB] FAIL reset_model: got %b want %b", act_vec(), exp_vec()); fails++;
    end
  endtask

  task automatic test_start();
    int starts;
    reset = 1; Btn = 0; cyc();
    reset = 0;
    repeat (3) begin
      cyc();
      tests++;
      if (act_vec() !== exp_vec() || Start !== 1'b0) begin
        $display("[TB] FAIL start_idle: got %b want %b", act_vec(), exp_vec()); fails++;
      end
    end
    Btn = 1; cyc();
    tests++;
    if (Start !== 1'b1 || Q_Play !== 1'b1 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL start_pulse: got %b want %b", act_vec(), exp_vec()); fails++;
    end
    starts = 0;
    repeat (3) begin
      cyc();
      if (Start === 1'b1) starts++;
    end
    tests++;
    if (starts !== 0 || Q_Play !== 1'b1) begin
      $display("[TB] FAIL start_single: extra starts %0d play %b want 0 and 1", starts, Q_Play); fails++;
    end
  endtask

  task automatic test_held_button();
    reset = 1; Btn = 1; cyc(); cyc();
    reset = 0;
    repeat (4) begin
      cyc();
      tests++;
      if (Start !== 1'b0 || Q_Idle !== 1'b1) begin
        $display("[TB] FAIL held_no_start: start %b idle %b want 0 1", Start, Q_Idle); fails++;
      end
    end
    Btn = 0; cyc();
    Btn = 1; cyc();
    tests++;
    if (Start !== 1'b1 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL held_restart: got %b want %b", act_vec(), exp_vec()); fails++;
    end
    Btn = 0; cyc();
  endtask

  task automatic test_glitch_filter();
    set_scene(150, 310, 390, 200, 300);
    Tick = 1; cyc(); Tick = 0; cyc();
    Bird_Y = 10'd250;
    Tick = 1; cyc(); Tick = 0; cyc();
    Bird_Y = 10'd150;
    Tick = 1; cyc(); Tick = 0; cyc();
    tests++;
    if (Q_Play !== 1'b1 || Stop !== 1'b0 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL glitch_stay_play: got %b want %b", act_vec(), exp_vec()); fails++;
    end
    Tick = 1; cyc(); Tick = 0;
    tests++;
    if (Q_Over !== 1'b1 || Stop !== 1'b1 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL glitch_over: got %b want %b", act_vec(), exp_vec()); fails++;
    end
  endtask

  task automatic test_restart_hold();
    Btn = 0; Tick = 0; cyc();
    repeat (OH - 1) begin Tick = 1; cyc(); Tick = 0; cyc(); end
    Btn = 1; cyc();
    tests++;
    if (Q_Over !== 1'b1 || Ack !== 1'b0) begin
      $display("[TB] FAIL hold_early_rise: over %b ack %b want 1 0", Q_Over, Ack); fails++;
    end
    Btn = 0; cyc();
    Btn = 1; Tick = 1; cyc();
    tests++;
    if (Q_Over !== 1'b1 || Ack !== 1'b0 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL hold_tick_rise: got %b want %b", act_vec(), exp_vec()); fails++;
    end
    Btn = 0; Tick = 0; cyc();
    Btn = 1; cyc();
    tests++;
    if (Ack !== 1'b1 || Stop !== 1'b0 || Q_Idle !== 1'b1) begin
      $display("[TB] FAIL hold_ack: ack %b stop %b idle %b want 1 0 1", Ack, Stop, Q_Idle); fails++;
    end
    Btn = 0; cyc();
    tests++;
    if (Ack !== 1'b0 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL hold_ack_pulse: got %b want %b", act_vec(), exp_vec()); fails++;
    end
  endtask

  task automatic test_floor_best();
    reset = 1; Btn = 0; Tick = 0; cyc();
    reset = 0;
    do_game(3);
    tests++;
    if (Best !== 4'd3 || Q_Over !== 1'b1) begin
      $display("[TB] FAIL floor_best3: best %0d over %b want 3 1", Best, Q_Over); fails++;
    end
    do_restart();
    do_game(5);
    tests++;
    if (Best !== 4'd5 || act_vec() !== exp_vec()) begin
      $display("[TB] FAIL floor_best5: got %b want %b", act_vec(), exp_vec()); fails++;
    end
    do_restart();
    do_game(2);
    tests++;
    if (Best !== 4'd5 || Q_Over !== 1'b1) begin
      $display("[TB] FAIL floor_best_hold: best %0d over %b want 5 1", Best, Q_Over); fails++;
    end
  endtask

  task automatic test_reset_mid_over();
    reset = 1; cyc();
    reset = 0;
    tests++;
    if (Q_Idle !== 1'b1 || Stop !== 1'b0 || Best !== 4'd0) begin
      $display("[TB] FAIL reset_over: idle %b stop %b best %0d want 1 0 0", Q_Idle, Stop, Best); fails++;
    end
  endtask

  task automatic test_random();
    int bad;
    int overlap;
    bad = 0;
    overlap = 0;
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) Btn = ~Btn;
      Tick = ($urandom_range(0, 1) == 1);
      Score = 4'($urandom_range(0, 15));
      X_Edge_L = 10'($urandom_range(200, 420));
      X_Edge_R = 10'(int'(X_Edge_L) + $urandom_range(0, 100));
      Gap_Top = 10'($urandom_range(50, 400));
      Gap_Bot = 10'(int'(Gap_Top) + $urandom_range(20, 250));
      if ($urandom_range(0, 9) == 0) Bird_Y = 10'($urandom_range(1000, 1023));
      else Bird_Y = 10'($urandom_range(40, 445));
      cyc();
      if (act_vec() !== exp_vec()) begin
        bad++;
        if (bad <= 5) $display("[TB] FAIL random_cycle_%0d: got %b want %b", i, act_vec(), exp_vec());
      end
      if (Start === 1'b1 && Ack === 1'b1) overlap++;
    end
    tests++;
    if (bad != 0) begin
      $display("[TB] FAIL random_model: %0d bad cycles, want 0", bad); fails++;
    end
    tests++;
    if (overlap != 0) begin
      $display("[TB] FAIL start_ack_overlap: %0d cycles, want 0", overlap); fails++;
    end
  endtask

  initial begin
    reset = 1; Btn = 0; Tick = 0; Score = 0;
    set_scene(100, 600, 700, 0, 1000);
    test_reset();
    test_start();
    test_held_button();
    test_glitch_filter();
    test_restart_hold();
    test_floor_best();
    test_reset_mid_over();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
